// File: rtl/sram2_arb_pkg.sv
// Shared constants and types for the SRAM2 two-port arbiter.
// Both requesters and the SRAM2 instance use these widths.
package sram2_arb_pkg;

  localparam int ADDR_W       = 13;
  localparam int DATA_W       = 128;
  localparam int BE_W         = DATA_W / 8;
  localparam int SRAM2_DEPTH  = 8000;
  localparam int ARB_HOLD_MAX = 4;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sram2_arb_fsm.sv
// Round-robin grant FSM with a bounded hold window. The grant is combinational
// from the current state and requests, so a port switch costs no bubble cycle.
module sram2_arb_fsm
  import sram2_arb_pkg::*;
#(
  parameter int HOLD_MAX = ARB_HOLD_MAX
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);

  arb_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;
  logic             r_last_owner, w_last_nxt;
  logic             w_win;
  logic             w_own;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    o_grant     = 2'b00;
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_last_nxt  = r_last_owner;
    w_win       = 1'b0;
    w_own       = (r_state == OWN1);

    unique case (r_state)
      IDLE: begin
        if (i_req != 2'b00) begin
          // On a tie the port that did not win last time goes first.
          w_win          = (i_req == 2'b11) ? ~r_last_owner : i_req[1];
          o_grant[w_win] = 1'b1;
          w_hold_nxt     = CNT_W'(1);
          w_state_nxt    = w_win ? OWN1 : OWN0;
        end
      end
      OWN0, OWN1: begin
        if (i_req[w_own] && (!i_req[~w_own] || r_hold_cnt < CNT_MAX)) begin
          o_grant[w_own] = 1'b1;
          w_hold_nxt     = (r_hold_cnt == CNT_MAX) ? CNT_MAX : r_hold_cnt + 1'b1;
        end else if (i_req[~w_own]) begin
          o_grant[~w_own] = 1'b1;
          w_hold_nxt      = CNT_W'(1);
          w_state_nxt     = w_own ? OWN0 : OWN1;
        end else begin
          w_hold_nxt  = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_hold_nxt  = '0;
        w_state_nxt = IDLE;
      end
    endcase

    if (o_grant != 2'b00) w_last_nxt = o_grant[1];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_hold_cnt   <= '0;
      r_last_owner <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_last_owner <= w_last_nxt;
    end
  end

endmodule

// File: rtl/sram2_arbiter.sv
// Shares the single-port SRAM2 between two Avalon-MM requesters: one access per
// cycle, range checking, sticky error flags and 1-cycle read response routing.
module sram2_arbiter
  import sram2_arb_pkg::*;
#(
  parameter int DEPTH    = SRAM2_DEPTH,
  parameter int HOLD_MAX = ARB_HOLD_MAX
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  output logic              m0_error,
  input  logic              m0_error_clr,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              m1_error,
  input  logic              m1_error_clr,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        w_req, w_fsm_grant, w_grant, w_err_set;
  logic              w_sel, w_acc, w_read, w_write, w_in_range, w_viol;
  logic [ADDR_W-1:0] w_addr;
  logic              r_rsp_valid, r_rsp_port, r_rsp_oor;
  logic [1:0]        r_err;

  assign w_req = {m1_read | m1_write, m0_read | m0_write};

  sram2_arb_fsm #(.HOLD_MAX(HOLD_MAX)) u_fsm (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (w_req),
    .o_grant (w_fsm_grant)
  );

  // No access may be accepted while reset is held.
  assign w_grant        = reset_n ? w_fsm_grant : 2'b00;
  assign m0_waitrequest = ~reset_n | (w_req[0] & ~w_grant[0]);
  assign m1_waitrequest = ~reset_n | (w_req[1] & ~w_grant[1]);

  assign w_sel      = w_grant[1];
  assign w_acc      = |w_grant;
  assign w_addr     = w_sel ? m1_address : m0_address;
  assign w_read     = w_sel ? m1_read    : m0_read;
  assign w_write    = w_sel ? m1_write   : m0_write;
  assign w_in_range = {1'b0, w_addr} < DEPTH_L;
  assign w_viol     = ~w_in_range | (w_read & w_write);
  assign w_err_set  = w_grant & {2{w_viol}};

  assign ram_address    = w_addr;
  assign ram_byteenable = w_sel ? m1_byteenable : m0_byteenable;
  assign ram_writedata  = w_sel ? m1_writedata  : m0_writedata;
  assign ram_chipselect = w_acc & w_in_range;
  assign ram_write      = ram_chipselect & w_write;
  assign ram_clken      = reset_n;

  // A read+write collision is executed as a write, so it yields no response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_port  <= 1'b0;
      r_rsp_oor   <= 1'b0;
      r_err       <= 2'b00;
    end else begin
      r_rsp_valid <= w_acc & w_read & ~w_write;
      r_rsp_port  <= w_sel;
      r_rsp_oor   <= ~w_in_range;
      r_err[0]    <= w_err_set[0] | (r_err[0] & ~m0_error_clr);
      r_err[1]    <= w_err_set[1] | (r_err[1] & ~m1_error_clr);
    end
  end

  assign m0_readdatavalid = r_rsp_valid & ~r_rsp_port;
  assign m1_readdatavalid = r_rsp_valid &  r_rsp_port;
  assign m0_readdata      = (m0_readdatavalid & ~r_rsp_oor) ? ram_readdata : '0;
  assign m1_readdata      = (m1_readdatavalid & ~r_rsp_oor) ? ram_readdata : '0;
  assign m0_error         = r_err[0];
  assign m1_error         = r_err[1];

endmodule

// File: tb/tb_sram2_arbiter.sv
// Directed bench for sram2_arbiter with a behavioural SRAM2 model behind it.
module tb_sram2_arbiter;
  import sram2_arb_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] m0_address, m1_address, ram_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable, ram_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, ram_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, ram_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic              m0_error, m1_error, m0_error_clr, m1_error_clr;
  logic              ram_chipselect, ram_write, ram_clken;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [DATA_W-1:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [DATA_W-1:0] D2 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [DATA_W-1:0] D3 = 128'h0F0F0F0F_A5A5A5A5_5A5A5A5A_F0F0F0F0;

  sram2_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m0_error(m0_error), .m0_error_clr(m0_error_clr),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .m1_error(m1_error), .m1_error_clr(m1_error_clr),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );

  always #5 clk = ~clk;

  // SRAM2 model: synchronous read (old data on a write cycle), byte-lane writes.
  logic [DATA_W-1:0] mem [0:8191];
  logic [DATA_W-1:0] ram_q;
  assign ram_readdata = ram_q;
  always @(posedge clk) begin
    if (ram_chipselect) begin
      for (int b = 0; b < BE_W; b++)
        if (ram_write && ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      ram_q <= mem[ram_address];
    end
  end

  task automatic set_idle();
    m0_read = 0; m0_write = 0; m0_error_clr = 0; m0_byteenable = '1;
    m1_read = 0; m1_write = 0; m1_error_clr = 0; m1_byteenable = '1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset_n = 0;
    next_cycle(); next_cycle();
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 1; set_idle();
    #2 reset_n = 0;
    m0_read = 1; m1_write = 1; m0_address = 13'h0A5; m1_address = 13'h001;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin n_bad++;
      $display("FAIL reset_wait: got %b%b want 11", m0_waitrequest, m1_waitrequest); end
    n_cmp++; if ({ram_chipselect, ram_write, ram_clken} !== 3'b000) begin n_bad++;
      $display("FAIL reset_ram: got cs/wr/clken %b%b%b want 000", ram_chipselect, ram_write, ram_clken); end
    n_cmp++; if ({m0_readdatavalid, m1_readdatavalid, m0_error, m1_error} !== 4'b0000) begin n_bad++;
      $display("FAIL reset_rsp_err: got %b%b%b%b want 0000", m0_readdatavalid, m1_readdatavalid, m0_error, m1_error); end
    set_idle();
    next_cycle();
    reset_n = 1;
    next_cycle();
  endtask

  task automatic test_write_read();
    m0_write = 1; m0_address = 13'h0A5; m0_writedata = D1; m0_byteenable = '1;
    @(negedge clk);
    n_cmp++; if ({ram_chipselect, ram_write, m0_waitrequest, m1_waitrequest} !== 4'b1100) begin n_bad++;
      $display("FAIL wr_strobe: got cs/wr/w0/w1 %b%b%b%b want 1100", ram_chipselect, ram_write, m0_waitrequest, m1_waitrequest); end
    n_cmp++; if (ram_address !== 13'h0A5 || ram_writedata !== D1) begin n_bad++;
      $display("FAIL wr_bus: got %h/%h want 0a5/%h", ram_address, ram_writedata, D1); end
    next_cycle();
    m0_write = 0; m0_read = 1;
    @(negedge clk);
    n_cmp++; if ({ram_chipselect, ram_write, m0_waitrequest} !== 3'b100) begin n_bad++;
      $display("FAIL rd_strobe: got cs/wr/w0 %b%b%b want 100", ram_chipselect, ram_write, m0_waitrequest); end
    next_cycle();
    set_idle();
    @(negedge clk);
    n_cmp++; if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0) begin n_bad++;
      $display("FAIL rd_valid: got %b%b want 10", m0_readdatavalid, m1_readdatavalid); end
    n_cmp++; if (m0_readdata !== D1) begin n_bad++;
      $display("FAIL rd_data: got %h want %h", m0_readdata, D1); end
    next_cycle();
  endtask

  task automatic test_lone_m1();
    next_cycle();
    m1_read = 1; m1_address = 13'h0A5;
    @(negedge clk);
    n_cmp++; if (m1_waitrequest !== 1'b0 || ram_chipselect !== 1'b1) begin n_bad++;
      $display("FAIL lone_m1_grant: got wait %b cs %b want 0 1", m1_waitrequest, ram_chipselect); end
    next_cycle();
    set_idle();
    @(negedge clk);
    n_cmp++; if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0 || m1_readdata !== D1) begin n_bad++;
      $display("FAIL lone_m1_rsp: got v1 %b v0 %b data %h want 1 0 %h", m1_readdatavalid, m0_readdatavalid, m1_readdata, D1); end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic exp0, prev0;
    m1_write = 1; m1_address = 13'h002; m1_writedata = D2;
    next_cycle();
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) begin
        m0_read = 1; m0_address = 13'h0A5; m1_read = 1; m1_address = 13'h002;
      end else set_idle();
      @(negedge clk);
      if (k < 16) begin
        exp0 = ((k / 4) % 2) == 0;
        n_cmp++; if (m0_waitrequest !== !exp0 || m1_waitrequest !== exp0) begin n_bad++;
          $display("FAIL rr_grant[%0d]: got w0 %b w1 %b want %b %b", k, m0_waitrequest, m1_waitrequest, !exp0, exp0); end
      end
      if (k > 0) begin
        prev0 = (((k - 1) / 4) % 2) == 0;
        n_cmp++; if (m0_readdatavalid !== prev0 || m1_readdatavalid !== !prev0) begin n_bad++;
          $display("FAIL rr_valid[%0d]: got %b%b want %b%b", k - 1, m0_readdatavalid, m1_readdatavalid, prev0, !prev0); end
        n_cmp++; if ((prev0 ? m0_readdata : m1_readdata) !== (prev0 ? D1 : D2)) begin n_bad++;
          $display("FAIL rr_data[%0d]: got %h want %h", k - 1, prev0 ? m0_readdata : m1_readdata, prev0 ? D1 : D2); end
      end
      next_cycle();
    end
  endtask

  task automatic test_out_of_range();
    m1_write = 1; m1_address = 13'd8000; m1_writedata = D3;
    @(negedge clk);
    n_cmp++; if ({ram_chipselect, ram_write, m1_waitrequest} !== 3'b000) begin n_bad++;
      $display("FAIL oor_wr: got cs/wr/w1 %b%b%b want 000", ram_chipselect, ram_write, m1_waitrequest); end
    next_cycle();
    m1_write = 0; m1_read = 1; m1_address = 13'd8191;
    @(negedge clk);
    n_cmp++; if (m1_error !== 1'b1 || ram_chipselect !== 1'b0) begin n_bad++;
      $display("FAIL oor_err_set: got err %b cs %b want 1 0", m1_error, ram_chipselect); end
    next_cycle();
    set_idle(); m1_error_clr = 1;
    @(negedge clk);
    n_cmp++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== '0) begin n_bad++;
      $display("FAIL oor_rd: got v %b data %h want 1 0", m1_readdatavalid, m1_readdata); end
    next_cycle();
    m1_read = 1; m1_address = 13'd8000; m1_error_clr = 1;
    @(negedge clk);
    n_cmp++; if (m1_error !== 1'b0) begin n_bad++;
      $display("FAIL err_clr: got %b want 0", m1_error); end
    next_cycle();
    set_idle();
    @(negedge clk);
    n_cmp++; if (m1_error !== 1'b1 || m0_error !== 1'b0) begin n_bad++;
      $display("FAIL err_set_wins: got m1 %b m0 %b want 1 0", m1_error, m0_error); end
    m1_error_clr = 1;
    next_cycle();
    m1_error_clr = 0;
    @(negedge clk);
    n_cmp++; if (m1_error !== 1'b0) begin n_bad++;
      $display("FAIL err_clr2: got %b want 0", m1_error); end
    next_cycle();
  endtask

  task automatic test_collision();
    m0_read = 1; m0_write = 1; m0_address = 13'h020; m0_writedata = D3;
    @(negedge clk);
    n_cmp++; if (ram_write !== 1'b1 || ram_chipselect !== 1'b1) begin n_bad++;
      $display("FAIL coll_wr: got wr %b cs %b want 1 1", ram_write, ram_chipselect); end
    next_cycle();
    m0_write = 0;
    @(negedge clk);
    n_cmp++; if (m0_error !== 1'b1 || m0_readdatavalid !== 1'b0) begin n_bad++;
      $display("FAIL coll_err: got err %b v %b want 1 0", m0_error, m0_readdatavalid); end
    next_cycle();
    set_idle(); m0_error_clr = 1;
    @(negedge clk);
    n_cmp++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== D3) begin n_bad++;
      $display("FAIL coll_readback: got v %b data %h want 1 %h", m0_readdatavalid, m0_readdata, D3); end
    next_cycle();
    m0_error_clr = 0;
  endtask

  task automatic test_byteenable();
    logic [DATA_W-1:0] exp_d;
    exp_d = {{(DATA_W-8){1'b1}}, 8'h00};
    m0_write = 1; m0_address = 13'h010; m0_writedata = '1; m0_byteenable = '1;
    next_cycle();
    m0_writedata = '0; m0_byteenable = 16'h0001;
    @(negedge clk);
    n_cmp++; if (ram_byteenable !== 16'h0001) begin n_bad++;
      $display("FAIL be_bus: got %h want 0001", ram_byteenable); end
    next_cycle();
    m0_write = 0; m0_read = 1;
    next_cycle();
    set_idle();
    @(negedge clk);
    n_cmp++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== exp_d) begin n_bad++;
      $display("FAIL be_readback: got v %b data %h want 1 %h", m0_readdatavalid, m0_readdata, exp_d); end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    m0_read = 1; m0_address = 13'h0A5;
    @(negedge clk);
    n_cmp++; if (m0_waitrequest !== 1'b0) begin n_bad++;
      $display("FAIL mid_accept: got %b want 0", m0_waitrequest); end
    #1 reset_n = 0;
    #1;
    n_cmp++; if ({m0_waitrequest, m1_waitrequest, ram_chipselect, ram_write, ram_clken} !== 5'b11000) begin n_bad++;
      $display("FAIL mid_reset_out: got %b%b%b%b%b want 11000", m0_waitrequest, m1_waitrequest, ram_chipselect, ram_write, ram_clken); end
    next_cycle();
    set_idle();
    n_cmp++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin n_bad++;
      $display("FAIL mid_reset_valid: got %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
    next_cycle();
    reset_n = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin n_bad++;
        $display("FAIL mid_release[%0d]: got %b%b want 00", k, m0_readdatavalid, m1_readdatavalid); end
      next_cycle();
    end
  endtask

  initial begin
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    test_reset();
    test_write_read();
    test_lone_m1();
    test_round_robin();
    test_out_of_range();
    test_collision();
    test_byteenable();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram2_arbiter.md
# sram2_arbiter

Two-port arbiter that shares the single-port 8000 x 128-bit on-chip SRAM2 between two Avalon-MM requesters, typically the sensor-sample logger (m0) and the Nios readout path (m1). It performs one access per cycle with round-robin fairness and a bounded hold window. It also performs out-of-range address checking and routes the 1-cycle read response back to the issuing port. It sits between the two requesters and the SRAM2 instance inside the SISTEMA system.

## Interface
- ADDR_W, 13, word address width
- DATA_W, 128, data width
- BE_W, 16, byteenable width (DATA_W/8)
- DEPTH, 8000, valid words; addresses >= DEPTH are out of range
- HOLD_MAX, 4, max consecutive grants to one port while the other is requesting (>=1)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- m0_address  in  ADDR_W  word address
- m0_byteenable  in  BE_W  write byte lanes
- m0_read  in  1  read request
- m0_write  in  1  write request
- m0_writedata  in  DATA_W  write data
- m0_waitrequest  out  1  request not accepted this cycle
- m0_readdata  out  DATA_W  read data, valid with readdatavalid, else 0
- m0_readdatavalid  out  1  read response strobe
- m0_error  out  1  sticky: out-of-range or read+write collision
- m0_error_clr  in  1  clears m0_error
- m1_address … m1_error_clr: same set, same widths and meaning, for port 1
- ram_address  out  ADDR_W  to SRAM address
- ram_byteenable  out  BE_W  to SRAM byteenable
- ram_writedata  out  DATA_W  to SRAM writedata
- ram_chipselect  out  1  access strobe
- ram_write  out  1  write strobe
- ram_clken  out  1  SRAM clock enable, held 1 outside reset
- ram_readdata  in  DATA_W  SRAM q (unregistered, valid 1 cycle after address)

## Operation
- Request on port x: mx_read | mx_write. Acceptance: request high and mx_waitrequest low in the same cycle.
- mx_waitrequest = request & ~grant_x (combinational). Non-requesting ports show 0.
- FSM states are IDLE, OWN0, OWN1. Registers: hold_cnt (saturating at HOLD_MAX) and last_owner (reset 1, so m0 wins first tie).
- IDLE:
  - Single requester is granted.
  - If both request, the port != last_owner is granted.
  - Go to OWNx with hold_cnt=1.
- OWNx:
  - If mx requests and (other idle or hold_cnt < HOLD_MAX): grant x, hold_cnt++.
  - Else if other requests: grant other, go to OWNother, hold_cnt=1.
  - Else: go to IDLE.
  - last_owner is updated on every grant.
- Granted access drives ram_address/byteenable/writedata from the winner. ram_chipselect=1, ram_write = winner's write.
- Read+write both high on one port: treated as a write, and error is set.
- Out-of-range address (>= DEPTH):
  - The access is still accepted, but ram_chipselect=0 and the write is dropped.
  - A read produces readdatavalid next cycle with readdata=0.
  - error is set.
- Read response: registered rsp_valid, rsp_port, rsp_oor.
  - mx_readdatavalid = rsp_valid & rsp_port==x.
  - mx_readdata = valid ? (rsp_oor ? 0 : ram_readdata) : 0.
- error: set has priority over error_clr in the same cycle.

## Timing
- Accept in cycle N → RAM strobes in N (combinational) → readdatavalid/readdata in N+1.
- Throughput: one access per cycle, any port mix. No bubbles on grant switch.
- Write in N, then read of the same address in N+1 (either port) returns the new data.
- During reset_n low, outputs are forced as follows:
  - waitrequest = 1
  - ram_chipselect = 0
  - ram_write = 0
  - ram_clken = 0
  - readdatavalid = 0
  - error = 0
  - FSM = IDLE, hold_cnt = 0, last_owner = 1
- Reset mid-read drops the pending response; no readdatavalid follows reset release.
- Requester deasserting while waiting is legal. No grant is recorded and the FSM follows the rules above.

## Structure
- Package sram2_arb_pkg: state enum {IDLE, OWN0, OWN1}, SRAM2_DEPTH=8000, ADDR_W/DATA_W/BE_W constants, port index constants.
- Sub-module sram2_arb_fsm: grant FSM, hold_cnt, last_owner. Outputs grant[1:0].
- Top: request muxing, range check, response pipeline, error flags.

## Test plan
- Reset, then m0 writes 0x0A5 (all bytes) = 0x1122…FF → ram_chipselect=ram_write=1 in the same cycle, m0_waitrequest=0; m0 reads 0x0A5 → readdatavalid next cycle with the same data, m1_readdatavalid=0.
- Both ports read continuously, HOLD_MAX=4 → grant pattern m0×4, m1×4, m0×4…; every response goes to the correct port with 1-cycle latency.
- Both request in the first cycle after reset → m0 granted first. A lone m1 request in IDLE is granted with zero wait.
- m1 writes address 8000 → ram_chipselect=0, m1_error=1; m1 reads 8191 → readdatavalid with data 0; m1_error_clr pulse → error 0, unless a new violation occurs in the same cycle (stays 1).
- m0 read accepted in cycle N, reset_n low in N → no readdatavalid after release, all outputs at reset values while low.
- m0 byteenable=0x0001 write to a location holding all-ones with data 0 → read back 0xFF…FF00.
